// File: rtl/layer_compositor.sv
// Priority compositor for LAYERS RGB332 planes with colour keying, a background colour,
// vsync-shadowed configuration, a 2-stage pipeline to RGB888 and a frame counter.
module layer_compositor #(
  parameter int LAYERS = 3,
  parameter int IDX_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  blank_in,
  input  logic [8*LAYERS-1:0]   layer_color,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [31:0]           cfg_data,
  output logic [7:0]            r_out,
  output logic [7:0]            g_out,
  output logic [7:0]            b_out,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic                  blank_out,
  output logic                  frame_drawn,
  output logic [15:0]           frame_count
);

  localparam int OW = LAYERS * IDX_W;

  function automatic logic [OW-1:0] default_order();
    logic [OW-1:0] o;
    o = '0;
    for (int s = 0; s < LAYERS; s++) o[s*IDX_W +: IDX_W] = IDX_W'(s);
    return o;
  endfunction

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return (c == 3'd0) ? 8'h00 : {c, 5'b11111};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return (c == 2'd0) ? 8'h00 : {c, 6'b111111};
  endfunction

  // Pending set is written by the host; active set only changes on a vsync rising edge.
  logic [LAYERS-1:0] en_pend_q, en_act_q;
  logic [7:0]        key_pend_q, key_act_q;
  logic [7:0]        bg_pend_q, bg_act_q;
  logic [OW-1:0]     ord_pend_q, ord_act_q;
  logic              vs_prev_q;
  logic              vs_rise;

  logic              unused_cfg;
  assign unused_cfg = ^cfg_data;

  assign vs_rise = vs_in & ~vs_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_pend_q  <= '1;
      en_act_q   <= '1;
      key_pend_q <= 8'h00;
      key_act_q  <= 8'h00;
      bg_pend_q  <= 8'h00;
      bg_act_q   <= 8'h00;
      ord_pend_q <= default_order();
      ord_act_q  <= default_order();
      vs_prev_q  <= 1'b0;
    end else begin
      vs_prev_q <= vs_in;
      if (vs_rise) begin
        en_act_q  <= en_pend_q;
        key_act_q <= key_pend_q;
        bg_act_q  <= bg_pend_q;
        ord_act_q <= ord_pend_q;
      end
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    en_pend_q  <= cfg_data[LAYERS-1:0];
          2'd1:    key_pend_q <= cfg_data[7:0];
          2'd2:    bg_pend_q  <= cfg_data[7:0];
          default: ord_pend_q <= cfg_data[OW-1:0];
        endcase
      end
    end
  end

  logic [LAYERS-1:0] opq_d;
  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_opaque
    assign opq_d[gi] = en_act_q[gi] && (layer_color[8*gi +: 8] != key_act_q);
  end

  // Stage 1 also captures the active order/bg so a pixel is always resolved
  // with the configuration that was active when it entered.
  logic [8*LAYERS-1:0] col_s1_q;
  logic [LAYERS-1:0]   opq_s1_q;
  logic [OW-1:0]       ord_s1_q;
  logic [7:0]          bg_s1_q;
  logic                hs_s1_q, vs_s1_q, blank_s1_q, rise_s1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_s1_q   <= '0;
      opq_s1_q   <= '0;
      ord_s1_q   <= '0;
      bg_s1_q    <= 8'h00;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      blank_s1_q <= 1'b1;
      rise_s1_q  <= 1'b0;
    end else begin
      col_s1_q   <= layer_color;
      opq_s1_q   <= opq_d;
      ord_s1_q   <= ord_act_q;
      bg_s1_q    <= bg_act_q;
      hs_s1_q    <= hs_in;
      vs_s1_q    <= vs_in;
      blank_s1_q <= blank_in;
      rise_s1_q  <= vs_rise;
    end
  end

  // Scan from the bottom slot upward so the lowest-numbered opaque slot wins.
  logic [7:0] sel_d;
  always_comb begin
    sel_d = bg_s1_q;
    for (int s = LAYERS - 1; s >= 0; s--) begin
      for (int p = 0; p < LAYERS; p++) begin
        if ((int'(ord_s1_q[s*IDX_W +: IDX_W]) == p) && opq_s1_q[p]) sel_d = col_s1_q[8*p +: 8];
      end
    end
  end

  logic [7:0]  r_d, g_d, b_d;
  assign r_d = blank_s1_q ? 8'h00 : expand3(sel_d[7:5]);
  assign g_d = blank_s1_q ? 8'h00 : expand3(sel_d[4:2]);
  assign b_d = blank_s1_q ? 8'h00 : expand2(sel_d[1:0]);

  logic [7:0]  r_q, g_q, b_q;
  logic        hs_q, vs_q, blank_q, fd_q;
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      b_q     <= 8'h00;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_s1_q;
      vs_q    <= vs_s1_q;
      blank_q <= blank_s1_q;
      fd_q    <= rise_s1_q;
      cnt_q   <= cnt_q + {15'd0, rise_s1_q};
    end
  end

  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;
  assign hs_out      = hs_q;
  assign vs_out      = vs_q;
  assign blank_out   = blank_q;
  assign frame_drawn = fd_q;
  assign frame_count = cnt_q;

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter LAYERS, default 3, number of RGB332 input planes (legal range 2..8).
REQ-002 SHALL have parameter IDX_W, default 3, width of one priority-slot field (fixed 3 to cover LAYERS up to 8).
REQ-003 SHALL have port clk  input  1  pixel-rate clock, sole clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hs_in / vs_in / blank_in  input  1 each  timing strobes aligned with layer_color (vs_in active-high).
REQ-006 SHALL have port layer_color  input  8*LAYERS  RGB332 per plane; plane i occupies bits [8i+7:8i].
REQ-007 SHALL have port cfg_we  input  1  config write strobe.
REQ-008 SHALL have port cfg_addr  input  2  register select: 0 enable mask, 1 key color, 2 background color, 3 priority order.
REQ-009 SHALL have port cfg_data  input  32  write data, LSB-aligned.
REQ-010 SHALL have port r_out / g_out / b_out  output  8 each  expanded composited color.
REQ-011 SHALL have port hs_out / vs_out / blank_out  output  1 each  strobes delayed to match color latency.
REQ-012 SHALL have port frame_drawn  output  1  one-cycle pulse per frame.
REQ-013 SHALL have port frame_count  output  16  frames since reset.

Function
REQ-014 SHALL hold two register sets, pending and active: enable[LAYERS-1:0], key[7:0], bg[7:0], order[LAYERS*IDX_W-1:0] (slot 0 = topmost).
REQ-015 SHALL write cfg_data into the pending register selected by cfg_addr when cfg_we=1; active set never written directly.
REQ-016 SHALL copy pending to active on the cycle vs_in rises (vs_in=1, previous vs_in=0); a cfg_we in that same cycle updates pending only and the copied value is the pre-write pending.
REQ-017 SHALL treat plane p as opaque when enable[p]=1 and layer_color[p] != key.
REQ-018 SHALL select, scanning slots 0..LAYERS-1, the first slot whose referenced plane is opaque; if none, output bg.
REQ-019 SHALL ignore slot entries >= LAYERS (never opaque); duplicate entries are legal, and a plane absent from order is never shown.
REQ-020 SHALL use a 2-stage pipeline: stage 1 registers colors, opaque flags and strobes; stage 2 registers selected color, expansion and strobes; latency exactly 2 cycles input to output.
REQ-021 SHALL expand each channel: value 0 -> 8'h00; otherwise r,g={c[2:0],5'b11111}, b={c[1:0],6'b111111}.
REQ-022 SHALL force r_out/g_out/b_out to 0 whenever the delayed blank is 1.
REQ-023 SHALL assert frame_drawn for exactly one cycle, 2 cycles after the vs_in rising edge (aligned with vs_out rise).
REQ-024 SHALL increment frame_count on the same cycle frame_drawn is 1, wrapping 16'hFFFF -> 0.
REQ-025 SHALL treat vs_in held high as one edge only; no further pulse until vs_in falls and rises again.

Reset
REQ-026 SHALL, while reset=1, set pending and active: enable all-ones, key 8'h00, bg 8'h00, order slot i = i.
REQ-027 SHALL, while reset=1, clear pipeline: color outputs 0, hs_out 0, vs_out 0, blank_out 1, frame_drawn 0, frame_count 0, previous-vs_in 0.
REQ-028 SHALL, on reset mid-frame, discard in-flight pipeline contents; first valid output appears 2 cycles after reset deasserts.
REQ-029 SHALL, if vs_in is already high when reset deasserts, count the first sampled cycle as a rising edge.

Verification
REQ-030 SHALL cover defaults: LAYERS=3, layers {0x00,0xE0,0x1C}, blank 0 -> after 2 cycles r=0xFF,g=0,b=0 (layer 1, layer 0 keyed out).
REQ-031 SHALL cover priority shadowing: write order=slots{2,1,0} mid-frame -> output unchanged until next vs_in rise, then g=0xFF from layer 2.
REQ-032 SHALL cover all-transparent: enable=0 via pending+vsync, bg=0x03 -> r=0,g=0,b=0xFF.
REQ-033 SHALL cover blank and sync alignment: blank_in=1 with opaque layers -> colors 0 two cycles later; hs/vs/blank_out equal inputs delayed 2.
REQ-034 SHALL cover frame counting: 3 vs_in pulses, one held high 10 cycles -> exactly 3 frame_drawn pulses, frame_count=3; preset 0xFFFF path wraps to 0.
REQ-035 SHALL cover cfg_we coincident with vs_in rise -> active gets old pending; new value active after following edge.
